// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//   Accepts parallel words over a valid/ready handshake and serializes them
//   onto a single-bit stream, one bit per clock, for a downstream serial
//   sequence detector. A one-word pending buffer lets consecutive words
//   stream back to back with no idle cycle.
//
// Parameters
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   data_in     word to serialize, sampled only on a transfer edge
//   load_valid  data_in is valid
//   load_ready  a word can be accepted this cycle (= no pending word)
//   x           serial bit (registered)
//   x_valid     x carries a real data bit (registered)
//   busy        shifter holds a word in flight (registered)
//   done        high while the last bit of a word is on x (registered)
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           st, st_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] pend, pend_n;
  logic             pend_v, pend_v_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             x_n, x_valid_n, busy_n, done_n;
  logic             xfer;

  // Bit currently presented at the head of a shift-register image.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  // Consume the head bit so the next one moves into the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign load_ready = !pend_v;
  assign xfer       = load_valid && load_ready;

  always_comb begin
    st_n     = st;
    sh_n     = sh;
    pend_n   = pend;
    pend_v_n = pend_v;
    cnt_n    = cnt;
    unique case (st)
      IDLE: begin
        if (xfer) begin
          sh_n  = data_in;
          cnt_n = '0;
          st_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          sh_n  = advance(sh);
          cnt_n = cnt + 1'b1;
          if (xfer) begin
            pend_n   = data_in;
            pend_v_n = 1'b1;
          end
        end else if (pend_v) begin
          // pend_v=1 means load_ready=0, so no transfer can collide here.
          sh_n     = pend;
          pend_v_n = 1'b0;
          cnt_n    = '0;
        end else if (xfer) begin
          // Word arriving on the last-bit edge skips the pending buffer.
          sh_n  = data_in;
          cnt_n = '0;
        end else begin
          cnt_n = '0;
          st_n  = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase

    // Outputs are registered images of the next state, so they line up
    // with sh/cnt in the same cycle.
    busy_n    = (st_n == SHIFT);
    x_valid_n = (st_n == SHIFT);
    x_n       = (st_n == SHIFT) ? head(sh_n) : 1'b0;
    done_n    = (st_n == SHIFT) && (cnt_n == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      sh      <= '0;
      pend    <= '0;
      pend_v  <= 1'b0;
      cnt     <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      st      <= st_n;
      sh      <= sh_n;
      pend    <= pend_n;
      pend_v  <= pend_v_n;
      cnt     <= cnt_n;
      x       <= x_n;
      x_valid <= x_valid_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule
